// File: rtl/i2c_apb_sequencer.sv
// APB sequencer that initialises an I2C master core, then runs single-byte write/read
// transactions with status polling. Define I2C_SEQ_TIMEOUT_EN to bound polling by TIMEOUT.
module i2c_apb_sequencer #(
    parameter logic [7:0]  PRESCALER = 8'h04,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       pclk_i,
    input  logic       preset_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_err_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic       pwrite_o,
    output logic [7:0] paddr_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i
);
    localparam logic [7:0] GapLast = 8'(POLL_GAP - 1);
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        StInitPre, StInitCmd, StIdle, StWrAddr, StWrData, StWrEn,
        StPollWait, StPoll, StRdData, StDone
`ifdef I2C_SEQ_TIMEOUT_EN
        , StAbort
`endif
    } state_e;

    // PhIdle doubles as the psel=0 cycle between transfers and the address-load cycle.
    typedef enum logic [1:0] {PhIdle, PhSetup, PhAccess} phase_e;

    state_e     state_q, state_d;
    phase_e     ph_q, ph_d;
    logic [7:0] req_addr_q, req_addr_d;
    logic [7:0] req_data_q, req_data_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] rsp_data_q, rsp_data_d;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       rsp_err_q, rsp_err_d;
`endif

    logic       xfer, xfer_write, xfer_done;
    logic [7:0] xfer_addr, xfer_data;

    always_comb begin
        xfer       = 1'b1;
        xfer_write = 1'b1;
        xfer_addr  = 8'h00;
        xfer_data  = 8'h00;
        case (state_q)
            StInitPre: xfer_data = PRESCALER;
            StInitCmd: begin xfer_addr = 8'h01; xfer_data = 8'h20; end
            StWrAddr:  begin xfer_addr = 8'h04; xfer_data = req_addr_q; end
            StWrData:  begin xfer_addr = 8'h02; xfer_data = req_data_q; end
            StWrEn:    begin xfer_addr = 8'h01; xfer_data = 8'h60; end
            StPoll:    begin xfer_addr = 8'h03; xfer_write = 1'b0; end
            StRdData:  begin xfer_addr = 8'h02; xfer_write = 1'b0; end
`ifdef I2C_SEQ_TIMEOUT_EN
            StAbort:   begin xfer_addr = 8'h01; xfer_data = 8'h20; end
`endif
            default:   begin xfer = 1'b0; xfer_write = 1'b0; end
        endcase
    end

    assign xfer_done = xfer && (ph_q == PhAccess) && pready_i;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        gap_d      = gap_q;
        rsp_data_d = rsp_data_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        cnt_d      = cnt_q;
        rsp_err_d  = rsp_err_q;
`endif
        if (xfer) begin
            unique case (ph_q)
                PhIdle: begin
                    ph_d     = PhSetup;
                    paddr_d  = xfer_addr;
                    pwdata_d = xfer_data;
                    pwrite_d = xfer_write;
                end
                PhSetup:  ph_d = PhAccess;
                PhAccess: if (pready_i) ph_d = PhIdle;
                default:  ph_d = PhIdle;
            endcase
        end

        case (state_q)
            StInitPre: if (xfer_done) state_d = StInitCmd;
            StInitCmd: if (xfer_done) state_d = StIdle;
            StIdle: begin
                if (req_valid_i) begin
                    req_addr_d = req_addr_i;
                    req_data_d = req_data_i;
                    state_d    = StWrAddr;
`ifdef I2C_SEQ_TIMEOUT_EN
                    cnt_d      = 8'h00;
`endif
                end
            end
            StWrAddr: if (xfer_done) state_d = StWrData;
            StWrData: if (xfer_done) state_d = StWrEn;
            StWrEn: begin
                if (xfer_done) begin
                    state_d = StPollWait;
                    gap_d   = 8'h00;
                end
            end
            StPollWait: begin
                if (gap_q == GapLast) state_d = StPoll;
                else gap_d = gap_q + 8'd1;
            end
            StPoll: begin
                if (xfer_done) begin
                    if (prdata_i[0]) begin
                        state_d = StPollWait;
                        gap_d   = 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        if (cnt_q >= TimeoutLast) state_d = StAbort;
`endif
                    end else if (req_addr_q[0]) begin
                        state_d = StRdData;
                    end else begin
                        state_d    = StDone;
                        rsp_data_d = 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
                        rsp_err_d  = 1'b0;
`endif
                    end
                end
            end
            StRdData: begin
                if (xfer_done) begin
                    state_d    = StDone;
                    rsp_data_d = prdata_i;
`ifdef I2C_SEQ_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                end
            end
`ifdef I2C_SEQ_TIMEOUT_EN
            StAbort: begin
                if (xfer_done) begin
                    state_d    = StDone;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 1'b1;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StInitPre;
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q    <= StInitPre;
            ph_q       <= PhIdle;
            req_addr_q <= 8'h00;
            req_data_q <= 8'h00;
            paddr_q    <= 8'h00;
            pwdata_q   <= 8'h00;
            pwrite_q   <= 1'b0;
            gap_q      <= 8'h00;
            rsp_data_q <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            cnt_q      <= 8'h00;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            gap_q      <= gap_d;
            rsp_data_q <= rsp_data_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            cnt_q      <= cnt_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign psel_o      = (ph_q == PhSetup) || (ph_q == PhAccess);
    assign penable_o   = (ph_q == PhAccess);
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_data_o  = rsp_data_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Randomized bench: an APB slave/monitor process checks every transfer and response against
// a transaction-level model of the expected APB traffic and completions.
module tb_i2c_apb_sequencer;
    localparam int PollGapP = 3;
    localparam int TimeoutP = 4;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int MaxBusy = 6;
`else
    localparam int MaxBusy = 5;
`endif

    logic       pclk_i = 1'b0;
    logic       preset_n_i = 1'b0;
    logic       req_valid_i, req_ready_o;
    logic [7:0] req_addr_i, req_data_i;
    logic       rsp_valid_o, rsp_err_o;
    logic [7:0] rsp_data_o;
    logic       psel_o, penable_o, pwrite_o;
    logic [7:0] paddr_o, pwdata_o, prdata_i;
    logic       pready_i = 1'b1;

    i2c_apb_sequencer #(
        .PRESCALER (8'h04),
        .POLL_GAP  (PollGapP),
        .TIMEOUT   (TimeoutP)
    ) dut (
        .pclk_i      (pclk_i),
        .preset_n_i  (preset_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct packed {logic wr; logic [7:0] addr; logic [7:0] data;} xfer_t;
    typedef struct packed {logic [7:0] data; logic err; logic [7:0] polls;} rsp_t;

    xfer_t xq[$];
    rsp_t  rq[$];
    int    n_tests = 0, n_fail = 0;
    int    busy_target = 0, poll_idx = 0, pready_mode = 0, phase_id = 0;
    logic [7:0] rd_byte = 8'h00;
    logic  end_req = 1'b0;

    // Status register reports busy for the first busy_target polls of a transaction.
    assign prdata_i = (paddr_o == 8'h03) ? {7'd0, (poll_idx < busy_target)} : rd_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input logic [7:0] a, input logic [7:0] d, input int b,
                            input logic [7:0] rd);
        int   np;
        logic ab;
        np = b + 1;
        ab = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        if (b >= TimeoutP) begin
            np = TimeoutP;
            ab = 1'b1;
        end
`endif
        xq.push_back({1'b1, 8'h04, a});
        xq.push_back({1'b1, 8'h02, d});
        xq.push_back({1'b1, 8'h01, 8'h60});
        for (int i = 0; i < np; i++) xq.push_back({1'b0, 8'h03, 8'h00});
        if (ab) begin
            xq.push_back({1'b1, 8'h01, 8'h20});
            rq.push_back({8'h00, 1'b1, 8'(np)});
        end else if (a[0]) begin
            xq.push_back({1'b0, 8'h02, 8'h00});
            rq.push_back({rd, 1'b0, 8'(np)});
        end else begin
            rq.push_back({8'h00, 1'b0, 8'(np)});
        end
    endtask

    // Slave driver, protocol checker and scoreboard; everything sampled on the falling edge.
    initial begin : monitor
        logic       prev_sel, prev_en, prev_rdy, prev_wr, prev_rv, poll_inc, end_done;
        logic [7:0] prev_addr, prev_data, last_data;
        logic       last_err;
        int         idle_run, stall_cnt, acc_len, wd;
        xfer_t      x;
        rsp_t       e;
        prev_sel = 0; prev_en = 0; prev_rdy = 0; prev_wr = 0; prev_rv = 0; poll_inc = 0;
        end_done = 0; prev_addr = 0; prev_data = 0; last_data = 0; last_err = 0;
        idle_run = 0; stall_cnt = 0; acc_len = 0; wd = 0;
        forever begin
            @(negedge pclk_i);
            if (poll_inc) begin
                poll_idx++;
                poll_inc = 1'b0;
            end
            if (!preset_n_i) begin
                chk("reset_vals", {psel_o, penable_o, pwrite_o, req_ready_o, rsp_valid_o,
                                   rsp_err_o, paddr_o, pwdata_o, rsp_data_o}, 32'd0);
                xq.delete();
                rq.delete();
                xq.push_back({1'b1, 8'h00, 8'h04});
                xq.push_back({1'b1, 8'h01, 8'h20});
                prev_sel = 0; prev_en = 0; prev_rdy = 0; prev_rv = 0;
                last_data = 0; last_err = 0; idle_run = 0; stall_cnt = 0; wd = 0;
                pready_i = 1'b1;
            end else begin
                chk("req_ready", req_ready_o, (xq.size() == 0 && rq.size() == 0));
                if (rsp_valid_o) begin
                    chk("rsp_single_cycle", prev_rv, 0);
                    chk("rsp_pending", rq.size() > 0, 1);
                    chk("rsp_xfers_done", xq.size(), 0);
                    if (rq.size() > 0) begin
                        e = rq.pop_front();
                        chk("rsp_data", rsp_data_o, e.data);
                        chk("rsp_err", rsp_err_o, e.err);
                        chk("rsp_polls", poll_idx, e.polls);
                        last_data = e.data;
                        last_err  = e.err;
                    end
                    if (phase_id == 1) begin
                        chk("lit_wr_polls", poll_idx, 4);
                        chk("lit_wr_rsp", {rsp_err_o, rsp_data_o}, 9'h000);
                    end
                    if (phase_id == 2) chk("lit_rd_data", rsp_data_o, 8'h3C);
                    if (phase_id == 4) begin
                        chk("lit_to_polls", poll_idx, 4);
                        chk("lit_to_err", rsp_err_o, 1);
                    end
                    wd = 0;
                end else begin
                    chk("rsp_hold", {rsp_err_o, rsp_data_o}, {last_err, last_data});
                end

                if (psel_o && penable_o) begin
                    acc_len++;
                    if (pready_mode == 2 && pwrite_o && paddr_o == 8'h02 && stall_cnt < 5) begin
                        pready_i = 1'b0;
                        stall_cnt++;
                    end else if (pready_mode == 1) begin
                        pready_i = ($urandom_range(0, 3) != 0);
                    end else begin
                        pready_i = 1'b1;
                    end
                end else begin
                    pready_i  = 1'b1;
                    stall_cnt = 0;
                end

                if (prev_sel && !(prev_en && prev_rdy)) begin
                    chk("apb_hold", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o},
                        {2'b11, prev_wr, prev_addr, prev_data});
                end else if (prev_sel) begin
                    chk("apb_gap", psel_o, 0);
                end else if (psel_o) begin
                    chk("apb_setup", penable_o, 0);
                    acc_len = 0;
                    if (paddr_o == 8'h03 && !pwrite_o) chk("poll_gap", idle_run >= PollGapP, 1);
                end else begin
                    chk("penable_idle", penable_o, 0);
                end

                if (psel_o && penable_o && pready_i) begin
                    wd = 0;
                    chk("xfer_expected", xq.size() > 0, 1);
                    if (xq.size() > 0) begin
                        x = xq.pop_front();
                        chk("xfer_dir", pwrite_o, x.wr);
                        chk("xfer_addr", paddr_o, x.addr);
                        if (x.wr) chk("xfer_wdata", pwdata_o, x.data);
                    end
                    if (!pwrite_o && paddr_o == 8'h03) poll_inc = 1'b1;
                    if (phase_id == 3 && pwrite_o && paddr_o == 8'h02) chk("stall_len", acc_len, 6);
                end

                if (req_valid_i && req_ready_o) begin
                    push_txn(req_addr_i, req_data_i, busy_target, rd_byte);
                    poll_idx = 0;
                    poll_inc = 1'b0;
                end

                if (xq.size() + rq.size() > 0) wd++;
                else wd = 0;
                if (wd > 1500) begin
                    chk("watchdog", wd, 0);
                    wd = 0;
                end
                if (end_req && !end_done) begin
                    chk("queues_empty", xq.size() + rq.size(), 0);
                    end_done = 1'b1;
                end
                prev_sel  = psel_o;
                prev_en   = penable_o;
                prev_rdy  = pready_i;
                prev_wr   = pwrite_o;
                prev_addr = paddr_o;
                prev_data = pwdata_o;
                prev_rv   = rsp_valid_o;
                idle_run  = psel_o ? 0 : idle_run + 1;
            end
        end
    end

    task automatic step();
        @(posedge pclk_i);
        #2;
    endtask

    task automatic start_req(input logic [7:0] a, input logic [7:0] d, input int b,
                             input logic [7:0] rd);
        busy_target = b;
        rd_byte     = rd;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        for (int i = 0; i < 3000; i++) begin
            if (req_ready_o) break;
            step();
        end
        step();
        req_valid_i = 1'b0;
    endtask

    // Random req_valid noise while busy must be ignored by the sequencer.
    task automatic wait_rsp();
        for (int i = 0; i < 6000; i++) begin
            step();
            if (rsp_valid_o) break;
            req_valid_i = 1'($urandom_range(0, 1));
            req_addr_i  = 8'($urandom);
            req_data_i  = 8'($urandom);
        end
        req_valid_i = 1'b0;
        step();
    endtask

    initial begin : stimulus
        req_valid_i = 1'b0;
        req_addr_i  = 8'h00;
        req_data_i  = 8'h00;
        repeat (3) step();
        phase_id    = 1;
        busy_target = 3;
        req_valid_i = 1'b1;
        req_addr_i  = 8'hAA;
        req_data_i  = 8'h55;
        step();
        preset_n_i = 1'b1;
        start_req(8'hAA, 8'h55, 3, 8'h00);
        wait_rsp();
        phase_id = 2;
        start_req(8'hA1, 8'h00, 0, 8'h3C);
        wait_rsp();
        phase_id    = 3;
        pready_mode = 2;
        start_req(8'h42, 8'h99, 1, 8'h00);
        wait_rsp();
        phase_id    = 5;
        pready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            start_req(8'($urandom), 8'($urandom), int'($urandom_range(0, MaxBusy)),
                      8'($urandom));
            wait_rsp();
        end
        pready_mode = 0;
`ifdef I2C_SEQ_TIMEOUT_EN
        phase_id = 4;
        start_req(8'h20, 8'h11, 1000, 8'h00);
        wait_rsp();
`endif
        phase_id = 6;
        start_req(8'h31, 8'h00, 1000, 8'h00);
        for (int i = 0; i < 2000; i++) begin
            if (psel_o && !pwrite_o && paddr_o == 8'h03) break;
            step();
        end
        preset_n_i = 1'b0;
        step();
        step();
        preset_n_i = 1'b1;
        phase_id   = 7;
        start_req(8'h33, 8'h00, 2, 8'h5A);
        wait_rsp();
        end_req = 1'b1;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : global_bound
        #800000;
        $display("FAIL global_timeout: simulation did not complete by %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/i2c_apb_sequencer.md
I2C_APB_SEQUENCER -- requirements
Module: i2c_apb_sequencer

Interface
REQ-001 SHALL have parameter PRESCALER, default 8'h04, prescaler value written at init.
REQ-002 SHALL have parameter POLL_GAP, default 4, idle pclk cycles between status polls (range 1-255).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum status polls per transaction.
REQ-004 pclk_i  in  1  sole clock; all logic on rising edge.
REQ-005 preset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  1  requester has a transaction.
REQ-007 req_ready_o  out  1  sequencer accepts a transaction.
REQ-008 req_addr_i  in  8  {slave address[6:0], rw}; rw=1 read.
REQ-009 req_data_i  in  8  write byte; ignored for reads.
REQ-010 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-011 rsp_data_o  out  8  read byte; 0 for writes.
REQ-012 rsp_err_o  out  1  timeout flag, valid with rsp_valid_o.
REQ-013 psel_o, penable_o, pwrite_o  out  1 each  APB control toward i2c master.
REQ-014 paddr_o, pwdata_o  out  8 each  APB address/write data.
REQ-015 prdata_i  in  8, pready_i  in  1  APB read data/ready.

Function
REQ-016 Each APB transfer SHALL be: setup cycle (psel=1, penable=0), access cycles (psel=1, penable=1) held until pready_i=1, then one cycle with psel=0.
REQ-017 paddr_o/pwdata_o/pwrite_o SHALL be stable from setup through the completing access cycle.
REQ-018 States SHALL be: INIT_PRE, INIT_CMD, IDLE, WR_ADDR, WR_DATA, WR_EN, POLL_WAIT, POLL, RD_DATA, ABORT, DONE.
REQ-019 After reset: INIT_PRE writes PRESCALER to 0x00; INIT_CMD writes 0x20 to 0x01; then IDLE.
REQ-020 req_ready_o SHALL be 1 only in IDLE; accept on req_valid_i & req_ready_o, latching req_addr_i/req_data_i.
REQ-021 Accepted transaction: WR_ADDR writes latched addr to 0x04; WR_DATA writes latched data to 0x02; WR_EN writes 0x60 to 0x01.
REQ-022 POLL_WAIT SHALL idle POLL_GAP cycles, then POLL reads 0x03; prdata_i[0]=1 (busy) returns to POLL_WAIT, 0 proceeds.
REQ-023 On not-busy: rw=1 -> RD_DATA reads 0x02, captures prdata_i; rw=0 -> DONE with data 0.
REQ-024 DONE SHALL assert rsp_valid_o for exactly one cycle with rsp_data_o/rsp_err_o, then IDLE (req_ready_o=1 next cycle).
REQ-025 rsp_data_o/rsp_err_o SHALL hold value until next DONE.
REQ-026 Poll counter SHALL be 8 bits, cleared on acceptance, saturating at 255.
REQ-027 req_valid_i outside IDLE SHALL be ignored (no latch, no loss of held request).

Reset
REQ-028 Reset SHALL force INIT_PRE; psel/penable/pwrite/req_ready/rsp_valid/rsp_err = 0; paddr/pwdata/rsp_data = 0x00.
REQ-029 Reset mid-transfer SHALL drop psel_o immediately and restart initialisation on release.

Configuration
REQ-030 Macro I2C_SEQ_TIMEOUT_EN defined: after TIMEOUT busy polls, ABORT writes 0x20 to 0x01, then DONE with rsp_err_o=1, rsp_data_o=0.
REQ-031 Macro undefined: polling unbounded, no counter, no ABORT state, rsp_err_o tied 0.

Verification
REQ-032 Reset release, pready_i=1 -> writes (0x00,0x04) then (0x01,0x20); req_ready_o=1 afterward.
REQ-033 Write req addr=0xAA data=0x55, status busy 3 polls -> writes 0x04=0xAA, 0x02=0x55, 0x01=0x60; 4 reads of 0x03; rsp_valid 1 cycle, data 0x00, err 0.
REQ-034 Read req addr=0xA1, status idle, prdata 0x3C at 0x02 -> rsp_data_o=0x3C, err 0.
REQ-035 pready_i low 5 cycles on WR_DATA access -> psel/penable/paddr/pwdata held stable, no skipped transfer.
REQ-036 I2C_SEQ_TIMEOUT_EN, TIMEOUT=4, status stuck busy -> 4 polls, write 0x01=0x20, rsp_err_o=1; reset during POLL -> psel_o=0 at once, init sequence repeats.
